// File: rtl/uart_tx_sched_if.sv
// Byte-stream bundle between N packet sources, the scheduler and the UART transmitter.
interface uart_tx_sched_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           uart_tx_valid;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_ready;

  // Environment side: sources plus the transmitter.
  modport master (
    output req_valid, req_data, req_last, uart_tx_ready,
    input  req_ready, uart_tx_valid, uart_tx_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, req_last, uart_tx_ready,
    output req_ready, uart_tx_valid, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler sharing one UART transmitter among N byte-stream sources,
// with an optional per-packet source-ID header byte.
module uart_tx_sched #(
  parameter int          N           = 4,
  parameter int          ID_W        = 2,
  parameter int          HEADER_EN   = 1,
  parameter logic [7:0]  HDR_BASE    = 8'hA0,
  parameter logic [15:0] GAP_TIMEOUT = 16'd4096
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_sched_if.slave  bus,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            abort
);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0] grant_reg, grant_next;
  logic [7:0]      byte_reg, byte_next;
  logic            last_reg, last_next;
  logic [15:0]     gap_cnt_reg, gap_cnt_next;

  logic [ID_W-1:0] cand_idx [N];
  logic [N-1:0]    rot_valid;
  logic [ID_W-1:0] sel_idx;
  logic            sel_found;
  logic [ID_W-1:0] grant_inc;
  logic            fetch_hs;

  // Candidate k is source (rr_ptr + k) mod N, so rot_valid is the request vector rotated to rr_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [ID_W:0] sum;
      assign sum           = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
      assign cand_idx[gi]  = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N)) : sum[ID_W-1:0];
      assign rot_valid[gi] = bus.req_valid[cand_idx[gi]];
    end
  endgenerate

  // Descending scan so the lowest rotated offset overwrites and wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  assign grant_inc = (grant_reg == ID_W'(N - 1)) ? '0 : grant_reg + 1'b1;
  assign fetch_hs  = (state_reg == FETCH) && bus.req_valid[grant_reg];

  always_comb begin
    bus.req_ready = '0;
    if (state_reg == FETCH) begin
      bus.req_ready[grant_reg] = bus.req_valid[grant_reg];
    end
  end

  assign bus.uart_tx_valid = (state_reg == ISSUE) && bus.uart_tx_ready;
  assign bus.uart_tx_data  = byte_reg;
  assign grant_id          = grant_reg;
  assign busy              = (state_reg != IDLE);

  // Counter is held at zero outside FETCH, so it always starts from zero on entry.
  assign gap_cnt_next = (state_reg == FETCH && !fetch_hs) ? gap_cnt_reg + 16'd1 : 16'd0;

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    byte_next   = byte_reg;
    last_next   = last_reg;
    abort       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          grant_next = sel_idx;
          state_next = (HEADER_EN != 0) ? HDR : FETCH;
        end
      end
      HDR: begin
        byte_next  = HDR_BASE | 8'(grant_reg);
        last_next  = 1'b0;
        state_next = ISSUE;
      end
      FETCH: begin
        // An accepted byte takes priority over a timeout in the same cycle.
        if (fetch_hs) begin
          byte_next  = bus.req_data[{grant_reg, 3'b000} +: 8];
          last_next  = bus.req_last[grant_reg];
          state_next = ISSUE;
        end else if (GAP_TIMEOUT != 16'd0 && gap_cnt_reg == GAP_TIMEOUT) begin
          abort       = 1'b1;
          rr_ptr_next = grant_inc;
          state_next  = IDLE;
        end
      end
      ISSUE: begin
        if (bus.uart_tx_ready) state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.uart_tx_ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.uart_tx_ready) begin
          if (last_reg) begin
            rr_ptr_next = grant_inc;
            state_next  = IDLE;
          end else begin
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      grant_reg   <= '0;
      byte_reg    <= 8'd0;
      last_reg    <= 1'b0;
      gap_cnt_reg <= 16'd0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      grant_reg   <= grant_next;
      byte_reg    <= byte_next;
      last_reg    <= last_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: source queues, a lagging transmitter model, and a
// scoreboard monitor that checks every transmitted byte against the expected stream.
module tb_uart_tx_sched;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_id;
  logic       busy;
  logic       abort;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.N(N)) bus ();

  uart_tx_sched #(
    .N(N), .ID_W(2), .HEADER_EN(1), .HDR_BASE(8'hA0), .GAP_TIMEOUT(16'd16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .grant_id(grant_id), .busy(busy), .abort(abort)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [$];

  // Transmitter model: ready drops one cycle after accepting, stays low 8 cycles.
  logic hold_low = 1'b0;
  logic tx_rdy_q;
  logic tx_pend;
  int   tx_cnt;
  logic tx_acc = 1'b0;

  assign bus.uart_tx_ready = tx_rdy_q & ~hold_low;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_rdy_q <= 1'b1;
      tx_pend  <= 1'b0;
      tx_cnt   <= 0;
    end else begin
      if (tx_pend) begin
        tx_rdy_q <= 1'b0;
        tx_cnt   <= 8;
        tx_pend  <= 1'b0;
      end else if (tx_cnt != 0) begin
        tx_cnt <= tx_cnt - 1;
        if (tx_cnt == 1) tx_rdy_q <= 1'b1;
      end
      if (tx_acc) tx_pend <= 1'b1;
    end
  end

  // Source driver: presents queue heads, pops on handshake seen in the previous cycle.
  logic [N-1:0] hs;
  always begin
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = src_q[i][0][7:0];
        bus.req_last[i]        = src_q[i][0][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'd0;
        bus.req_last[i]        = 1'b0;
      end
    end
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (reset) src_q[i].delete();
      else if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  end

  // Monitor / scoreboard.
  int   cyc = 0, pulses = 0, abort_cnt = 0, abort_cyc = 0, rise_cyc = 0, viol = 0;
  logic prev_valid = 1'b0, prev_rdy = 1'b0, atom_watch = 1'b0;
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    tx_acc = bus.uart_tx_valid & bus.uart_tx_ready;
    if (bus.uart_tx_valid) begin
      pulses++;
      chk("no_back_to_back", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {24'd0, bus.uart_tx_data}, 32'h100);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", {24'd0, bus.uart_tx_data}, {24'd0, e});
      end
    end
    prev_valid = bus.uart_tx_valid;
    if (bus.uart_tx_ready && !prev_rdy) rise_cyc = cyc;
    prev_rdy = bus.uart_tx_ready;
    if (abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (atom_watch && busy && grant_id == 2'd0 && bus.req_ready[1]) viol++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic src_byte(input int s, input logic [7:0] d, input logic l);
    src_q[s].push_back({l, d});
    exp_q.push_back(d);
  endtask

  task automatic exp_hdr(input int s);
    exp_q.push_back(8'hA0 | 8'(s));
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int maxc);
    int k = 0;
    while (k < maxc && !(exp_q.size() == 0 && !busy && srcs_empty())) begin
      tick(1);
      k++;
    end
    chk(name, {31'd0, (k < maxc)}, 32'd1);
  endtask

  task automatic wait_grant(input string name, input int s, input int maxc);
    int k = 0;
    while (k < maxc && !(busy && grant_id == 2'(s))) begin
      tick(1);
      k++;
    end
    chk(name, {31'd0, (k < maxc)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int k;
    reset = 1'b1;
    tick(3);
    chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.uart_tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.uart_tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_abort", {31'd0, abort}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Single packet from source 2.
    exp_hdr(2);
    src_byte(2, 8'h41, 1'b0);
    src_byte(2, 8'h42, 1'b1);
    wait_idle("t1_done", 400);
    chk("t1_rr_ptr", {30'd0, dut.rr_ptr_reg}, 32'd3);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Contention from reset: 0, 1, 3, then 0 again via wrap.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    exp_hdr(0); src_byte(0, 8'h10, 1'b0); src_byte(0, 8'h11, 1'b1);
    exp_hdr(1); src_byte(1, 8'h20, 1'b1);
    exp_hdr(3); src_byte(3, 8'h30, 1'b0); src_byte(3, 8'h31, 1'b1);
    wait_grant("t2_grant3", 3, 2000);
    exp_hdr(0); src_byte(0, 8'h40, 1'b1);
    wait_idle("t2_done", 2000);
    chk("t2_rr_ptr", {30'd0, dut.rr_ptr_reg}, 32'd1);

    // Atomicity: source 1 waits for source 0's whole packet.
    exp_hdr(0); src_byte(0, 8'h50, 1'b0); src_byte(0, 8'h51, 1'b0); src_byte(0, 8'h52, 1'b1);
    wait_grant("t3_grant0", 0, 200);
    atom_watch = 1'b1;
    exp_hdr(1); src_byte(1, 8'h60, 1'b1);
    wait_idle("t3_done", 2000);
    atom_watch = 1'b0;
    chk("t3_no_ready1", viol, 32'd0);
    chk("t3_rr_ptr", {30'd0, dut.rr_ptr_reg}, 32'd2);

    // Gap timeout: one non-last byte, then nothing.
    abort_cnt = 0;
    exp_hdr(0); src_byte(0, 8'h70, 1'b0);
    k = 0;
    while (k < 400 && abort_cnt == 0) begin
      tick(1);
      k++;
    end
    chk("t4_abort_seen", {31'd0, (abort_cnt > 0)}, 32'd1);
    tick(3);
    chk("t4_abort_once", abort_cnt, 32'd1);
    chk("t4_abort_delay", abort_cyc - rise_cyc, 32'd17);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_rr_ptr", {30'd0, dut.rr_ptr_reg}, 32'd1);
    exp_hdr(1); src_byte(1, 8'h80, 1'b1);
    wait_idle("t4_done", 400);

    // Transmitter held not-ready for 50 cycles while in ISSUE.
    hold_low = 1'b1;
    p0 = pulses;
    exp_hdr(2); src_byte(2, 8'h90, 1'b1);
    tick(50);
    chk("t5_no_pulse_held", pulses - p0, 32'd0);
    chk("t5_valid_low", {31'd0, bus.uart_tx_valid}, 32'd0);
    hold_low = 1'b0;
    #1;
    chk("t5_pulse_on_rise", {31'd0, bus.uart_tx_valid}, 32'd1);
    wait_idle("t5_done", 400);
    chk("t5_pulse_count", pulses - p0, 32'd2);

    // Asynchronous reset during WAIT_DONE of the second data byte.
    p0 = pulses;
    exp_hdr(3); src_byte(3, 8'h11, 1'b0); src_byte(3, 8'h22, 1'b0);
    src_q[3].push_back({1'b1, 8'h33});
    k = 0;
    while (k < 500 && pulses < p0 + 3) begin
      tick(1);
      k++;
    end
    chk("t6_reached_byte2", {31'd0, (pulses >= p0 + 3)}, 32'd1);
    tick(5);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_grant_id", {30'd0, grant_id}, 32'd0);
    chk("t6_tx_data", {24'd0, bus.uart_tx_data}, 32'd0);
    chk("t6_tx_valid", {31'd0, bus.uart_tx_valid}, 32'd0);
    chk("t6_req_ready", {28'd0, bus.req_ready}, 32'd0);
    tick(2);
    reset = 1'b0;
    chk("t6_rr_ptr", {30'd0, dut.rr_ptr_reg}, 32'd0);
    exp_hdr(0); src_byte(0, 8'h55, 1'b1);
    wait_idle("t6_done", 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
